// File: rtl/spi_pkg.sv
// Shared types and limits for the SPI responder slice.
package spi_pkg;

  typedef enum logic [0:0] {
    SLV_IDLE  = 1'b0,
    SLV_SHIFT = 1'b1
  } spi_slv_state_e;

  localparam int SPI_MIN_SYNC = 2;

endpackage

// File: rtl/spi_sync.sv
// N-stage flip-flop synchronizer for one asynchronous input bit.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Depths below two give no metastability protection, so clamp upward.
  localparam int N = (STAGES < SPI_MIN_SYNC) ? SPI_MIN_SYNC : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {N{RST_VAL}};
    else        sync_q <= {sync_q[N-2:0], d};
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/spi_slave_core.sv
// SPI mode-0 responder: oversampled pins, MSB-first shifting, single-entry tx holding register.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_TX     = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_p0, sclk_p1;
  logic rise, fall;

  spi_slv_state_e state, state_nxt;
  logic frame_start, frame_end, active;

  logic [DATA_W-1:0] tx_shift, tx_shift_nxt;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
  logic              load, underrun_nxt;
  logic [DATA_W-2:0] rx_shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_seen;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );

  // Stage p0/p1: edge detection on synchronized sclk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
    end else begin
      sclk_p0 <= sclk_s;
      sclk_p1 <= sclk_p0;
    end
  end

  assign rise = sclk_p0 & ~sclk_p1;
  assign fall = ~sclk_p0 & sclk_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLV_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLV_IDLE:  if (!cs_n_s) state_nxt = SLV_SHIFT;
      SLV_SHIFT: if (cs_n_s)  state_nxt = SLV_IDLE;
      default:   state_nxt = SLV_IDLE;
    endcase
  end

  // Edges arriving in the cycle cs_n deasserts are ignored: the frame is already over.
  always_comb begin
    frame_start = (state == SLV_IDLE)  && (state_nxt == SLV_SHIFT);
    frame_end   = (state == SLV_SHIFT) && (state_nxt == SLV_IDLE);
    active      = (state == SLV_SHIFT) && (state_nxt == SLV_SHIFT);
    busy        = (state == SLV_SHIFT);
  end

  assign tx_ready = ~hold_full;

  always_comb begin
    load         = frame_start | (active & fall & (bit_cnt == '0) & word_seen);
    underrun_nxt = load & ~hold_full;
    tx_shift_nxt = tx_shift;
    if (frame_end)            tx_shift_nxt = '0;
    else if (load)            tx_shift_nxt = hold_full ? hold_data : IDLE_TX;
    else if (active && fall)  tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
  end

  // Stage p2: transmit path registers and holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      miso        <= 1'b0;
      tx_underrun <= 1'b0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
    end else begin
      tx_shift    <= tx_shift_nxt;
      miso        <= (state_nxt == SLV_SHIFT) ? tx_shift_nxt[DATA_W-1] : 1'b0;
      tx_underrun <= underrun_nxt;
      if (tx_valid && !hold_full) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (load && hold_full) begin
        hold_full <= 1'b0;
      end
    end
  end

  // Stage p2: receive path; a partial word is dropped when the frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      bit_cnt   <= '0;
      word_seen <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (frame_start || frame_end) begin
        rx_shift  <= '0;
        bit_cnt   <= '0;
        word_seen <= 1'b0;
      end else if (active && rise) begin
        rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};
        if (bit_cnt == LAST_BIT) begin
          rx_data   <= {rx_shift, mosi_s};
          rx_valid  <= 1'b1;
          bit_cnt   <= '0;
          word_seen <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
